register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry x XLEN general-purpose integer register file for the RV32I single-cycle core.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Sits between decode, which supplies the addresses, and the ALU/writeback mux, which supplies write_data.
- x0 is hardwired to zero per the RISC-V ISA.

Parameters:
- XLEN, 32 (riscv_pkg), data width of each register and port.
- REG_ADDR_WIDTH, 5 (riscv_pkg), register address width.
- NUM_REGS, 2**REG_ADDR_WIDTH (local), number of architectural registers.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- reg_write_enable  input  1  write strobe for rd port.
- rs1_addr  input  REG_ADDR_WIDTH  read port 1 address.
- rs2_addr  input  REG_ADDR_WIDTH  read port 2 address.
- rd_addr  input  REG_ADDR_WIDTH  write port address.
- write_data  input  XLEN  data written to rd.
- rs1_data  output  XLEN  contents of register rs1_addr.
- rs2_data  output  XLEN  contents of register rs2_addr.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset:
  - rst_n low immediately clears all registers to 0, independent of clk.
  - While rst_n is low, rs1_data = rs2_data = 0 and writes are ignored.
  - Reset deassertion mid-operation: the first write takes effect at the first rising edge with rst_n high.
- Write:
  - On posedge clk with rst_n high, reg_write_enable=1 and rd_addr!=0: regs[rd_addr] <= write_data.
  - reg_write_enable=0 leaves all registers unchanged.
  - Writes to rd_addr=0 are discarded.
- Read:
  - Purely combinational, zero latency.
  - rs1_data = (rs1_addr==0) ? 0 : regs[rs1_addr]; rs2 likewise.
  - Both ports may address the same register simultaneously and return identical data.
- Read/write same register, same cycle:
  - No internal bypass; the read returns the old value until the clock edge, then the new value after it (flop output).
  - Forwarding, if needed, is the core's responsibility.
- No X propagation: every register has a defined reset value; outputs are never X after reset.
- Full address range 0..31 is valid; there is no out-of-range case.

Decomposition:
- riscv_pkg holds XLEN, REG_ADDR_WIDTH, and optionally typedefs data_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_ADDR_WIDTH-1:0]).
- The register file imports riscv_pkg.
- Single flat module: array of NUM_REGS x XLEN flops with async-reset always_ff, plus two always_comb read muxes. No sub-module needed.

Test Plan:
- Reset check: hold rst_n=0, read all 32 addresses on both ports -> every read returns 32'h00000000.
- Write/readback sweep: reg_write_enable=1, write value 32'hA5A50000+i to register i for i=0..31 (one per clock), then set reg_write_enable=0 and read pairs (i, 31-i). Required responses:
  - reads of x0 return 0;
  - reads of xi (i!=0) return A5A50000+i;
  - compare using !== to catch X.
- Write-enable gating: write 32'hDEADBEEF to x5 with reg_write_enable=0 -> rs1_addr=5 still returns the prior value 32'hA5A50005.
- Same-cycle read/write: rs1_addr=rd_addr=7, write 32'h12345678 -> rs1_data shows the old value before the edge and 32'h12345678 after it; rs2_addr=7 concurrently gives the same result.
- Async reset mid-run: after the sweep, pulse rst_n low between clock edges -> all outputs drop to 0 immediately, with no clock edge required; subsequent write of 32'h00000001 to x1 reads back 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core parameters and datapath types.
package riscv_pkg;
  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [XLEN-1:0]           data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/register_file.sv
// 32 x XLEN integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero.
module register_file
  import riscv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reg_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [XLEN-1:0]           write_data,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  data_t regs_q [NUM_REGS];
  data_t regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reg_write_enable && (rd_addr != '0)) begin
      regs_d[rd_addr] = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write bypass: reads see flop outputs, forwarding lives in the core.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      rs2_data = regs_q[rs2_addr];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with an expected-value queue.
module tb_register_file;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        reg_write_enable;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reg_write_enable (reg_write_enable),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rd_addr          (rd_addr),
    .write_data       (write_data),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Push expectations, drive both read addresses, compare after settling.
  task automatic rd_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
    sb_q.push_back(e1);
    sb_q.push_back(e2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    chk({tag, "_rs1"}, rs1_data);
    chk({tag, "_rs2"}, rs2_data);
  endtask

  task automatic wr(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write_enable = we;
    rd_addr          = a;
    write_data       = d;
    @(posedge clk);
    #1;
    reg_write_enable = 1'b0;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : (32'hA5A50000 + i);
  endfunction

  initial begin
    rst_n            = 1'b0;
    reg_write_enable = 1'b1;
    rs1_addr         = '0;
    rs2_addr         = '0;
    rd_addr          = 5'd3;
    write_data       = 32'hFFFFFFFF;

    // Reset held with a write strobe active: everything must read zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd_pair("reset", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end
    reg_write_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Write sweep including x0, then pairwise readback.
    for (int i = 0; i < 32; i++) begin
      wr(1'b1, 5'(i), 32'hA5A50000 + i);
    end
    for (int i = 0; i < 32; i++) begin
      rd_pair("sweep", 5'(i), 5'(31 - i), sweep_val(i), sweep_val(31 - i));
    end

    // Write-enable gating.
    wr(1'b0, 5'd5, 32'hDEADBEEF);
    rd_pair("we_gate", 5'd5, 5'd5, 32'hA5A50005, 32'hA5A50005);

    // Same-cycle read/write of x7: old value before the edge, new after.
    @(negedge clk);
    reg_write_enable = 1'b1;
    rd_addr          = 5'd7;
    write_data       = 32'h12345678;
    rd_pair("rw_before", 5'd7, 5'd7, 32'hA5A50007, 32'hA5A50007);
    @(posedge clk);
    #1;
    reg_write_enable = 1'b0;
    rd_pair("rw_after", 5'd7, 5'd7, 32'h12345678, 32'h12345678);

    // Asynchronous reset asserted in the low phase, no clock edge in between.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rd_pair("async_rst_a", 5'd7, 5'd31, 32'h0, 32'h0);
    rd_pair("async_rst_b", 5'd1, 5'd5, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wr(1'b1, 5'd1, 32'h00000001);
    rd_pair("post_rst", 5'd1, 5'd2, 32'h00000001, 32'h0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
